// File: rtl/interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl
//   Multi-source interrupt controller placed in front of the PC/flag save
//   stage. It latches rising edges on the request lines into pending flags,
//   qualifies them with a per-source mask and a global enable, and picks a
//   winner by fixed priority (bit 0 highest). It issues a one-cycle int_req,
//   waits one cycle for int_ack, and then tracks the handler until RETI.
//
// Handshake: int_req is a single-cycle pulse (the REQ state). The save
//   stage answers by holding int_ack high during the following cycle
//   (WAIT_ACK). If int_ack is high at the end of that cycle the request is
//   taken. If it is low the request is dropped, the pending flag is kept,
//   and the request is raised again once it is eligible. int_ack is ignored
//   in every other state, and reti_signal is ignored outside SERVICE.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   irq_in        raw request lines, rising-edge significant
//   mask_we/wdata mask register write (1 = source enabled)
//   ei/di_signal  set / clear global enable (di wins when both are high)
//   int_ack       save stage has captured PC/C/Z
//   reti_signal   handler finished
//   int_req       request pulse to the save stage
//   int_en        global interrupt enable
//   int_vector    handler address of the current/last granted source
//   int_id        index of the current/last granted source
//   int_active    handler in service
//   pend_q        pending flags
//   mask_q        mask register
//   dbg_state     FSM state, for checkers (0 IDLE,1 REQ,2 WAIT_ACK,3 SERVICE)
// ---------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter int                 d_width    = 12,
  parameter int                 n_src      = 4,
  parameter int                 id_w       = 2,
  parameter logic [d_width-1:0] vec_base   = 12'h100,
  parameter int                 vec_stride = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [n_src-1:0]   irq_in,
  input  logic               mask_we,
  input  logic [n_src-1:0]   mask_wdata,
  input  logic               ei_signal,
  input  logic               di_signal,
  input  logic               int_ack,
  input  logic               reti_signal,
  output logic               int_req,
  output logic               int_en,
  output logic [d_width-1:0] int_vector,
  output logic [id_w-1:0]    int_id,
  output logic               int_active,
  output logic [n_src-1:0]   pend_q,
  output logic [n_src-1:0]   mask_q,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_SERVICE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [n_src-1:0]   r_irq_d;
  logic [n_src-1:0]   r_pend;
  logic [n_src-1:0]   r_mask;
  logic               r_gie;
  logic               r_int_req;
  logic               r_int_active;
  logic [id_w-1:0]    r_int_id;
  logic [d_width-1:0] r_int_vector;

  logic [n_src-1:0]   w_rise;
  logic [n_src-1:0]   w_eligible;
  logic [n_src-1:0]   w_ack_clr;
  logic [id_w-1:0]    w_winner;
  logic               w_any;
  logic [d_width-1:0] w_vector;
  logic               w_ack_take;
  logic               w_reti_take;
  logic               w_gie_nxt;

  assign w_rise      = irq_in & ~r_irq_d;
  assign w_eligible  = r_pend & r_mask;
  assign w_any       = |w_eligible;
  assign w_ack_take  = (r_state == ST_WAIT_ACK) && int_ack;
  assign w_reti_take = (r_state == ST_SERVICE) && reti_signal;
  assign w_ack_clr   = w_ack_take ? (n_src'(1) << r_int_id) : '0;

  // Scan from the top down so the lowest set index is the final winner.
  always_comb begin
    w_winner = '0;
    for (int i = n_src - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = id_w'(i);
    end
  end

  assign w_vector = vec_base + d_width'(w_winner) * d_width'(vec_stride);

  // ei/di first, then acknowledge/reti override them.
  always_comb begin
    w_gie_nxt = r_gie;
    if (ei_signal)   w_gie_nxt = 1'b1;
    if (di_signal)   w_gie_nxt = 1'b0;
    if (w_ack_take)  w_gie_nxt = 1'b0;
    if (w_reti_take) w_gie_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_irq_d      <= '0;
      r_pend       <= '0;
      r_mask       <= '0;
      r_gie        <= 1'b0;
      r_int_req    <= 1'b0;
      r_int_active <= 1'b0;
      r_int_id     <= '0;
      r_int_vector <= '0;
    end else begin
      r_irq_d <= irq_in;
      // A new edge in the same cycle as the acknowledge clear keeps the flag.
      r_pend  <= (r_pend & ~w_ack_clr) | w_rise;
      r_gie   <= w_gie_nxt;
      if (mask_we) r_mask <= mask_wdata;

      case (r_state)
        ST_IDLE: begin
          if (r_gie && w_any) begin
            r_state      <= ST_REQ;
            r_int_req    <= 1'b1;
            r_int_id     <= w_winner;
            r_int_vector <= w_vector;
          end
        end
        ST_REQ: begin
          r_state   <= ST_WAIT_ACK;
          r_int_req <= 1'b0;
        end
        ST_WAIT_ACK: begin
          if (int_ack) begin
            r_state      <= ST_SERVICE;
            r_int_active <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (reti_signal) begin
            r_state      <= ST_IDLE;
            r_int_active <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign int_req    = r_int_req;
  assign int_en     = r_gie;
  assign int_vector = r_int_vector;
  assign int_id     = r_int_id;
  assign int_active = r_int_active;
  assign pend_q     = r_pend;
  assign mask_q     = r_mask;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        ei_signal;
  logic        di_signal;
  logic        int_ack;
  logic        reti_signal;
  logic        int_req;
  logic        int_en;
  logic [11:0] int_vector;
  logic [1:0]  int_id;
  logic        int_active;
  logic [3:0]  pend_q;
  logic [3:0]  mask_q;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 idle, 1 request, 2 waiting for ack, 3 in service
  int          m_phase;
  int          m_id;
  logic [11:0] m_vec;
  logic [3:0]  m_pend;
  logic [3:0]  m_mask;
  logic        m_gie;
  logic [3:0]  m_irq_d;
  logic [11:0] exp_q[$];

  interrupt_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ei_signal(ei_signal), .di_signal(di_signal),
    .int_ack(int_ack), .reti_signal(reti_signal), .int_req(int_req),
    .int_en(int_en), .int_vector(int_vector), .int_id(int_id),
    .int_active(int_active), .pend_q(pend_q), .mask_q(mask_q),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_id = 0; m_vec = '0; m_pend = '0; m_mask = '0;
    m_gie = 1'b0; m_irq_d = '0;
    exp_q.delete();
  endtask

  // One clock edge of the specified behaviour, from the current inputs.
  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] elig;
    logic       ack_t, reti_t, g;
    int         win;
    rise   = irq_in & ~m_irq_d;
    elig   = m_pend & m_mask;
    ack_t  = (m_phase == 2) && int_ack;
    reti_t = (m_phase == 3) && reti_signal;
    g = m_gie;
    if (ei_signal) g = 1'b1;
    if (di_signal) g = 1'b0;
    if (ack_t)     g = 1'b0;
    if (reti_t)    g = 1'b1;
    if (ack_t) m_pend[m_id] = 1'b0;
    case (m_phase)
      0: if (m_gie && elig != 0) begin
           win = 0;
           while (!elig[win]) win++;
           m_id  = win;
           m_vec = 12'(32'h100 + win * 4);
           exp_q.push_back(m_vec);
           m_phase = 1;
         end
      1: m_phase = 2;
      2: m_phase = int_ack ? 3 : 0;
      default: if (reti_signal) m_phase = 0;
    endcase
    m_pend  = m_pend | rise;
    if (mask_we) m_mask = mask_wdata;
    m_gie   = g;
    m_irq_d = irq_in;
  endtask

  task automatic check_outputs();
    chk("int_req",    32'(int_req),    32'(m_phase == 1));
    chk("int_active", 32'(int_active), 32'(m_phase == 3));
    chk("int_en",     32'(int_en),     32'(m_gie));
    chk("int_id",     32'(int_id),     32'(m_id));
    chk("int_vector", 32'(int_vector), 32'(m_vec));
    chk("pend_q",     32'(pend_q),     32'(m_pend));
    chk("mask_q",     32'(mask_q),     32'(m_mask));
    if (int_req) begin
      if (exp_q.size() == 0) chk("sb_unexpected_req", 32'(int_req), 32'(0));
      else                   chk("sb_grant_vector", 32'(int_vector), 32'(exp_q.pop_front()));
    end
  endtask

  // Driver: called right after a falling edge, returns after the next one.
  task automatic cyc(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                     input logic ei, input logic di, input logic ack, input logic reti);
    irq_in = irq; mask_we = mwe; mask_wdata = mwd;
    ei_signal = ei; di_signal = di; int_ack = ack; reti_signal = reti;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic [3:0] irq, input bit auto_ack, input bit auto_reti);
    for (int k = 0; k < n; k++)
      cyc(irq, 1'b0, 4'h0, 1'b0, 1'b0, auto_ack && (m_phase == 2), auto_reti && (m_phase == 3));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},    32'(int_req),    32'(0));
    chk({tag, "_en"},     32'(int_en),     32'(0));
    chk({tag, "_vector"}, 32'(int_vector), 32'(0));
    chk({tag, "_id"},     32'(int_id),     32'(0));
    chk({tag, "_active"}, 32'(int_active), 32'(0));
    chk({tag, "_pend"},   32'(pend_q),     32'(0));
    chk({tag, "_mask"},   32'(mask_q),     32'(0));
  endtask

  // Assert reset between edges and look at the outputs before any clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in = 4'b0001; mask_we = 0; mask_wdata = 0;
    ei_signal = 0; di_signal = 0; int_ack = 0; reti_signal = 0;
    model_reset();
    #1 check_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Line held high across reset release: pending but not requested.
    run(3, 4'b0001, 1'b0, 1'b0);
    chk("tp1_pend", 32'(pend_q), 32'(4'b0001));
    cyc(4'b0001, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    run(1, 4'b0001, 1'b0, 1'b0);
    chk("tp1_req", 32'(int_req), 32'(1));
    chk("tp1_vec", 32'(int_vector), 32'(12'h100));
    run(2, 4'b0001, 1'b1, 1'b0);
    run(1, 4'b0001, 1'b0, 1'b1);

    // Simultaneous rises on sources 1 and 2.
    run(1, 4'b0000, 1'b0, 1'b0);
    run(1, 4'b0110, 1'b0, 1'b0);
    run(3, 4'b0110, 1'b1, 1'b0);
    chk("tp2_id1",     32'(int_id), 32'(1));
    chk("tp2_vec104",  32'(int_vector), 32'(12'h104));
    chk("tp2_en_off",  32'(int_en), 32'(0));
    chk("tp2_active",  32'(int_active), 32'(1));
    run(1, 4'b0110, 1'b0, 1'b1);
    run(1, 4'b0110, 1'b0, 1'b0);
    chk("tp2_req2",    32'(int_req), 32'(1));
    chk("tp2_vec108",  32'(int_vector), 32'(12'h108));

    // No acknowledge: drop back to idle and retry.
    run(2, 4'b0110, 1'b0, 1'b0);
    chk("tp3_pend_kept", 32'(pend_q[2]), 32'(1));
    run(1, 4'b0110, 1'b0, 1'b0);
    chk("tp3_retry_req", 32'(int_req), 32'(1));
    run(2, 4'b0110, 1'b1, 1'b0);
    chk("tp3_pend_clr", 32'(pend_q), 32'(0));
    run(1, 4'b0110, 1'b0, 1'b1);
    run(2, 4'b0000, 1'b0, 1'b0);

    // ei and di together: di wins.
    cyc(4'b0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp4_eidi", 32'(int_en), 32'(0));
    cyc(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    run(4, 4'b0001, 1'b1, 1'b0);
    run(4, 4'b1001, 1'b0, 1'b0);
    chk("tp4_pend3", 32'(pend_q[3]), 32'(1));
    run(1, 4'b1001, 1'b0, 1'b1);
    run(1, 4'b1001, 1'b0, 1'b0);
    chk("tp4_vec10c", 32'(int_vector), 32'(12'h10C));
    run(2, 4'b1001, 1'b1, 1'b0);
    run(1, 4'b1001, 1'b0, 1'b1);
    run(2, 4'b0000, 1'b0, 1'b0);

    // Acknowledge clear and new rise on the same source in one cycle.
    run(1, 4'b0001, 1'b0, 1'b0);
    run(2, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, m_phase == 2, 1'b0);
    chk("tp5_pend_set_wins", 32'(pend_q[0]), 32'(1));
    run(1, 4'b0001, 1'b0, 1'b1);
    run(1, 4'b0001, 1'b0, 1'b0);
    chk("tp5_reserve", 32'(int_req), 32'(1));
    run(2, 4'b0001, 1'b1, 1'b0);
    chk("tp6_in_service", 32'(int_active), 32'(1));

    // Reset in service, then nothing requested without mask and gie.
    async_reset("tp6");
    run(10, 4'b0001, 1'b1, 1'b0);
    chk("tp6_no_req", 32'(int_req), 32'(0));

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] irq, mwd;
      logic mwe, ei, di, ack, reti;
      irq = irq_in;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      mwe  = ($urandom_range(0, 31) == 0);
      mwd  = 4'($urandom_range(0, 15));
      ei   = ($urandom_range(0, 9) == 0);
      di   = ($urandom_range(0, 19) == 0);
      ack  = (m_phase == 2) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      reti = (m_phase == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      cyc(irq, mwe, mwd, ei, di, ack, reti);
      if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
Multi-source interrupt controller sitting directly upstream of the PC/flag save stage. Latches rising edges on n_src request lines, applies a per-source mask and a global enable, and arbitrates by fixed priority. Issues a one-cycle int_req with int_en to the save stage, and waits for its int_ack. Tracks the in-service period until reti_signal, and supplies the handler vector to the fetch unit.

Parameters:
d_width, 12, PC/vector width
n_src, 4, number of interrupt sources
id_w, 2, width of source index (must satisfy 2**id_w >= n_src)
vec_base, 12'h100, vector address of source 0
vec_stride, 4, address distance between consecutive source vectors

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
irq_in  input  n_src  raw interrupt lines, synchronous to clk, rising-edge significant
mask_we  input  1  write strobe for mask register
mask_wdata  input  n_src  new mask value (1 = source enabled)
ei_signal  input  1  EI instruction executed: set global enable
di_signal  input  1  DI instruction executed: clear global enable
int_ack  input  1  save stage has captured PC/C/Z
reti_signal  input  1  RETI executed: service complete
int_req  output  1  interrupt request pulse to save stage
int_en  output  1  global interrupt enable to save stage
int_vector  output  d_width  handler address of current/last granted source
int_id  output  id_w  index of current/last granted source
int_active  output  1  handler in service
pend_q  output  n_src  pending flags
mask_q  output  n_src  mask register

Behaviour:
- All state is cleared asynchronously while reset=1. Reset values: int_req=0, int_en=0, int_vector=0, int_id=0, int_active=0, pend_q=0, mask_q=0, irq_d=0, state=IDLE. Reset mid-operation abandons any request or service with no residue.
- Edge detect: irq_d <= irq_in each cycle; rise = irq_in & ~irq_d. Because irq_d is cleared by reset, a line held high across reset release counts as a rising edge in the first cycle after release.
- pend_q[i] is set on rise[i], regardless of mask or global enable. It is cleared only when source i is acknowledged. If the clear and a new rise for the same source fall in the same cycle, set wins.
- mask_q <= mask_wdata when mask_we=1. The new mask takes effect from the next cycle.
- gie (driven out as int_en) follows these rules:
  - ei_signal sets gie; di_signal clears it. If both are asserted in the same cycle, di wins.
  - The acknowledge clears gie (disable on entry). reti_signal in SERVICE sets gie.
  - Acknowledge/reti updates override ei/di in the same cycle.
- eligible = pend_q & mask_q. The winner is the lowest set index (bit 0 has highest priority).
- FSM:
  - IDLE: if gie=1 and eligible != 0, go to REQ. On that edge, latch int_id = winner and int_vector = vec_base + winner*vec_stride, truncated to d_width.
  - REQ: int_req=1 for exactly this one cycle. Always go to WAIT_ACK.
  - WAIT_ACK: int_req=0.
    - If int_ack=1: go to SERVICE, clear pend_q[int_id], clear gie.
    - Otherwise go to IDLE with pend_q unchanged, so the request is retried once it is again eligible.
  - SERVICE: int_active=1. New edges still latch into pend_q; there is no nesting or preemption. On reti_signal=1: go to IDLE, int_active=0, set gie.
- int_req and int_active are registered decodes of state; int_active is high only in SERVICE.
- Arbitration is frozen once REQ is entered: a higher-priority edge arriving in REQ or WAIT_ACK is not substituted, and it is served after reti.
- reti_signal outside SERVICE is ignored. int_ack outside WAIT_ACK is ignored.
- Timing: irq rise at edge N (pend set) leads to REQ from edge N+1 and WAIT_ACK from edge N+2. With the save stage registering ack, int_ack is high during WAIT_ACK, so SERVICE starts at edge N+3.
- int_vector and int_id hold their last value outside REQ, WAIT_ACK and SERVICE.

Test Plan:
- Reset release with irq_in=4'b0001, mask=0, gie=0 -> pend_q=0001, int_req never asserts; after mask_we with 4'b1111 and ei_signal -> int_req pulses 1 cycle, int_id=0, int_vector=12'h100.
- Simultaneous rises on sources 2 and 1, all enabled, int_ack returned the cycle after int_req -> source 1 is served first with int_vector=12'h104; int_en=0 and int_active=1 until reti; after reti, source 2 is requested with int_vector=12'h108.
- No int_ack in WAIT_ACK -> return to IDLE with pend_q bit still set and int_req re-pulsed 2 cycles later; then ack -> that pend bit clears.
- ei_signal and di_signal in the same cycle -> int_en=0. Rise on source 3 during SERVICE -> pend_q[3]=1 with no int_req until reti_signal, then int_vector=12'h10C.
- Same-cycle ack clear and new rise on the same source -> pend bit remains 1, and the source is served again after reti.
- Reset asserted while in SERVICE -> all outputs return to 0 immediately (asynchronously), with no request after release unless a new edge occurs and both mask and gie are set again.
